// File: rtl/io_wide_access_if.sv
// rtl/io_wide_access_if.sv - request and io_s bus signal bundle for io_wide_access
//
// Purpose: groups the core-side request/response signals and the 8-bit io_s
// peripheral bus signals of io_wide_access.
// Modports:
//   slave  - the sequencer: takes req*, bus_in; drives req_ready, done, rdata,
//            addr, wr, rd, bus_out.
//   master - the requester plus peripheral side (the opposite directions).
interface io_wide_access_if #(
  parameter int BUS_ADDR_DATA_LEN = 16
);
  logic                         req;
  logic                         req_wr;
  logic [BUS_ADDR_DATA_LEN-1:0] req_addr;
  logic [1:0]                   req_len;
  logic [31:0]                  req_wdata;
  logic                         req_ready;
  logic                         done;
  logic [31:0]                  rdata;
  logic [BUS_ADDR_DATA_LEN-1:0] addr;
  logic                         wr;
  logic                         rd;
  logic [7:0]                   bus_out;
  logic [7:0]                   bus_in;

  modport slave (
    input  req, req_wr, req_addr, req_len, req_wdata, bus_in,
    output req_ready, done, rdata, addr, wr, rd, bus_out
  );

  modport master (
    output req, req_wr, req_addr, req_len, req_wdata, bus_in,
    input  req_ready, done, rdata, addr, wr, rd, bus_out
  );
endinterface

// File: rtl/io_wide_access.sv
// rtl/io_wide_access.sv - sequences a 1..4 byte register access into io_s byte strobes
//
// Purpose: turns one 8/16/24/32-bit request into ordered byte strobes on the
// 8-bit io_s bus. Reads go byte 0 first (byte 0 snapshots the upper bytes in
// the peripheral), writes go byte 0 last (byte 0 commits the holding register).
// Optional feature macro: IO_WIDE_GAP_EN inserts one idle cycle between
// consecutive strobes for peripherals with registered decode.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   io   - io_wide_access_if.slave: req/req_wr/req_addr/req_len/req_wdata in,
//          req_ready/done/rdata out; io_s addr/wr/rd/bus_out out, bus_in in
module io_wide_access #(
  parameter int BUS_ADDR_DATA_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  io_wide_access_if.slave io
);
  localparam int AW = BUS_ADDR_DATA_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
`ifdef IO_WIDE_GAP_EN
    DONE = 2'd2,
    GAP  = 2'd3
`else
    DONE = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;        // byte index of the strobe currently on the bus
  logic [1:0]    left_q, left_d;  // strobes still to issue after the current one
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [7:0]    bus_out_q, bus_out_d;

  logic          lat_wr_q;
  logic [AW-1:0] lat_addr_q;
  logic [31:0]   lat_wdata_q;

  logic          accept;
  logic          step;
  logic [31:0]   keep_mask;

  assign accept = (state_q == IDLE) && io.req;

  // Bytes at or above N are cleared when a read is accepted.
  always_comb begin
    keep_mask = 32'hFFFF_FFFF;
    case (io.req_len)
      2'd0:    keep_mask = 32'h0000_00FF;
      2'd1:    keep_mask = 32'h0000_FFFF;
      2'd2:    keep_mask = 32'h00FF_FFFF;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    left_d    = left_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    bus_out_d = bus_out_q;
    step      = 1'b0;

    // The edge that ends a read strobe cycle captures that strobe's byte.
    if (rd_q) begin
      rdata_d[{k_q, 3'b000} +: 8] = io.bus_in;
    end

    case (state_q)
      IDLE: begin
        if (io.req) begin
          state_d = XFER;
          k_d     = io.req_wr ? io.req_len : 2'd0;
          left_d  = io.req_len;
          addr_d  = io.req_addr + AW'(k_d);
          wr_d    = io.req_wr;
          rd_d    = !io.req_wr;
          if (io.req_wr) begin
            bus_out_d = io.req_wdata[{k_d, 3'b000} +: 8];
          end else begin
            rdata_d = rdata_q & keep_mask;
          end
        end
      end
      XFER: begin
        if (left_q == 2'd0) begin
          state_d = DONE;
        end else begin
`ifdef IO_WIDE_GAP_EN
          state_d = GAP;
`else
          step    = 1'b1;
`endif
        end
      end
`ifdef IO_WIDE_GAP_EN
      GAP: begin
        state_d = XFER;
        step    = 1'b1;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Issue the next strobe: writes walk down towards byte 0, reads walk up.
    if (step) begin
      k_d    = lat_wr_q ? (k_q - 2'd1) : (k_q + 2'd1);
      left_d = left_q - 2'd1;
      addr_d = lat_addr_q + AW'(k_d);
      wr_d   = lat_wr_q;
      rd_d   = !lat_wr_q;
      if (lat_wr_q) begin
        bus_out_d = lat_wdata_q[{k_d, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      left_q      <= 2'd0;
      rdata_q     <= 32'd0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      bus_out_q   <= 8'd0;
      lat_wr_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      left_q    <= left_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      bus_out_q <= bus_out_d;
      if (accept) begin
        lat_wr_q    <= io.req_wr;
        lat_addr_q  <= io.req_addr;
        lat_wdata_q <= io.req_wdata;
      end
    end
  end

  assign io.req_ready = (state_q == IDLE);
  assign io.done      = (state_q == DONE);
  assign io.rdata     = rdata_q;
  assign io.addr      = addr_q;
  assign io.wr        = wr_q;
  assign io.rd        = rd_q;
  assign io.bus_out   = bus_out_q;
endmodule

// File: tb/tb_io_wide_access.sv
// tb/tb_io_wide_access.sv - self-checking bench for io_wide_access
module tb_io_wide_access;
`ifdef IO_WIDE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_wide_access_if #(.BUS_ADDR_DATA_LEN(16)) io ();

  io_wide_access #(.BUS_ADDR_DATA_LEN(16)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  // Peripheral model: byte storage indexed by the low address byte.
  logic [7:0] mem [0:255];
  logic       preload = 1'b1;

  assign io.bus_in = io.rd ? mem[io.addr[7:0]] : 8'hzz;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20] <= 8'hA5;
      mem[8'h21] <= 8'h01;
    end else if (io.wr && !rst) begin
      mem[io.addr[7:0]] <= io.bus_out;
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } strobe_t;

  strobe_t sq[$];
  vec_t    vecs[10];
  int      n_vec = 0;
  int      n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobe sequence for one request, computed from the byte ordering rules.
  task automatic push_exp(input vec_t v);
    int n;
    int k;
    strobe_t s;
    logic [31:0] wd;
    n  = int'(v.len) + 1;
    wd = v.wdata;
    for (int i = 0; i < n; i++) begin
      k      = v.wr ? (n - 1 - i) : i;
      s.wr   = v.wr;
      s.addr = v.addr + 16'(k);
      s.data = wd[8*k +: 8];
      s.cyc  = 1 + i * (1 + GAP);
      sq.push_back(s);
    end
  endtask

  // Walks cycles after acceptance, matching strobes against the queue until done.
  task automatic monitor(input logic [1:0] len, input logic [31:0] exp_rd);
    int      dcyc;
    bit      got;
    strobe_t s;
    dcyc = int'(len) * (1 + GAP) + 2;
    got  = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      chk("busy_req_ready", {31'd0, io.req_ready}, 32'd0);
      if (io.wr && io.rd) chk("wr_and_rd", 32'd1, 32'd0);
      if (io.wr || io.rd) begin
        if (sq.size() == 0) begin
          chk("extra_strobe_cycle", 32'(c), 32'd0);
        end else begin
          s = sq.pop_front();
          chk("strobe_wr", {31'd0, io.wr}, {31'd0, s.wr});
          chk("strobe_addr", {16'd0, io.addr}, {16'd0, s.addr});
          if (s.wr) chk("strobe_data", {24'd0, io.bus_out}, {24'd0, s.data});
          chk("strobe_cycle", 32'(c), 32'(s.cyc));
        end
      end
      if (io.done) begin
        got = 1'b1;
        chk("done_cycle", 32'(c), 32'(dcyc));
        chk("rdata", io.rdata, exp_rd);
        chk("missing_strobes", 32'(sq.size()), 32'd0);
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    sq.delete();
  endtask

  task automatic issue(input vec_t v);
    push_exp(v);
    @(negedge clk);
    chk("idle_req_ready", {31'd0, io.req_ready}, 32'd1);
    io.req       = 1'b1;
    io.req_wr    = v.wr;
    io.req_addr  = v.addr;
    io.req_len   = v.len;
    io.req_wdata = v.wdata;
    @(posedge clk);
    #1 io.req = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t v2;
    bit   quiet;

    io.req       = 1'b0;
    io.req_wr    = 1'b0;
    io.req_addr  = 16'd0;
    io.req_len   = 2'd0;
    io.req_wdata = 32'd0;

    vecs[0] = '{1'b1, 16'h0024, 2'd1, 32'h0000_0312, 32'h0000_0000};
    vecs[1] = '{1'b0, 16'h0020, 2'd1, 32'h0,         32'h0000_01A5};
    vecs[2] = '{1'b0, 16'h0024, 2'd0, 32'h0,         32'h0000_0012};
    vecs[3] = '{1'b1, 16'hFFFF, 2'd1, 32'h0000_ABCD, 32'h0000_0012};
    vecs[4] = '{1'b0, 16'hFFFF, 2'd1, 32'h0,         32'h0000_ABCD};
    vecs[5] = '{1'b1, 16'h0030, 2'd3, 32'hDEAD_BEEF, 32'h0000_ABCD};
    vecs[6] = '{1'b0, 16'h0030, 2'd3, 32'h0,         32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 16'h0031, 2'd2, 32'h0,         32'h00DE_ADBE};
    vecs[8] = '{1'b1, 16'h0040, 2'd0, 32'h1122_3344, 32'h00DE_ADBE};
    vecs[9] = '{1'b0, 16'h0040, 2'd1, 32'h0,         32'h0000_0044};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, io.req_ready}, 32'd1);
    chk("rst_done", {31'd0, io.done}, 32'd0);
    chk("rst_rdata", io.rdata, 32'd0);
    chk("rst_addr", {16'd0, io.addr}, 32'd0);
    chk("rst_wr_rd", {30'd0, io.wr, io.rd}, 32'd0);
    chk("rst_bus_out", {24'd0, io.bus_out}, 32'd0);
    rst     = 1'b0;
    preload = 1'b0;

    // Table-driven transfers.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      monitor(vecs[i].len, vecs[i].exp_rdata);
      if (i == 0) chk("periph_period", {16'd0, mem[8'h25], mem[8'h24]}, 32'h0000_0312);
    end
    chk("periph_upper_ignored", {24'd0, mem[8'h41]}, 32'd0);

    // Busy: second request held from the first XFER cycle through DONE.
    v  = '{1'b0, 16'h0030, 2'd3, 32'h0, 32'hDEAD_BEEF};
    v2 = '{1'b1, 16'h0050, 2'd0, 32'h0000_0077, 32'hDEAD_BEEF};
    issue(v);
    io.req       = 1'b1;
    io.req_wr    = v2.wr;
    io.req_addr  = v2.addr;
    io.req_len   = v2.len;
    io.req_wdata = v2.wdata;
    monitor(v.len, v.exp_rdata);
    @(negedge clk);
    chk("busy_ready_after_done", {31'd0, io.req_ready}, 32'd1);
    chk("busy_no_early_strobe", {30'd0, io.wr, io.rd}, 32'd0);
    push_exp(v2);
    @(posedge clk);
    #1 io.req = 1'b0;
    monitor(v2.len, v2.exp_rdata);
    chk("busy_second_written", {24'd0, mem[8'h50]}, 32'h0000_0077);

    // Reset after the first strobe of a 4-byte write.
    @(negedge clk);
    io.req       = 1'b1;
    io.req_wr    = 1'b1;
    io.req_addr  = 16'h0060;
    io.req_len   = 2'd3;
    io.req_wdata = 32'h0102_0304;
    @(posedge clk);
    #1 io.req = 1'b0;
    @(negedge clk);
    chk("abort_first_wr", {31'd0, io.wr}, 32'd1);
    chk("abort_first_addr", {16'd0, io.addr}, 32'h0000_0063);
    chk("abort_first_data", {24'd0, io.bus_out}, 32'h0000_0001);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_rd", {30'd0, io.wr, io.rd}, 32'd0);
    chk("abort_done", {31'd0, io.done}, 32'd0);
    chk("abort_req_ready", {31'd0, io.req_ready}, 32'd1);
    chk("abort_rdata", io.rdata, 32'd0);
    rst   = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (io.wr || io.rd || io.done || !io.req_ready) quiet = 1'b0;
    end
    chk("abort_stays_idle", {31'd0, quiet}, 32'd1);

    // Recovery after the abort.
    v = '{1'b0, 16'h0024, 2'd0, 32'h0, 32'h0000_0012};
    issue(v);
    monitor(v.len, v.exp_rdata);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
